// File: rtl/stl_pkg.sv
// Shared SerialTL packet-path definitions: packet width, source field geometry
// and the response-buffer state encoding.
package stl_pkg;

    localparam int unsigned PKT_W           = 128;
    localparam int unsigned SRC_W           = 8;
    localparam int unsigned SRC_LSB_DEFAULT = 24;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned STRAY_W         = 8;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/stl_outstanding_ctr.sv
// Per-requester in-flight transaction counter with full/zero flags and a
// timeout flush that discards every outstanding transaction at once.
module stl_outstanding_ctr
    import stl_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             zero
);

    logic dec_ok;

    // A delivery against an already-flushed counter must not wrap it
    assign dec_ok = dec && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({inc, dec_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full = (count == CNT_W'(MAX_OUTSTANDING));
    assign zero = (count == '0);

endmodule

// File: rtl/stl_txn_arbiter.sv
// Two-requester round-robin arbiter for the SerialTL packet path: tags request
// sources with the requester index, routes tagged responses back, flushes on timeout.
module stl_txn_arbiter
    import stl_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ      = 100_000_000,
    parameter int unsigned SRC_LSB         = SRC_LSB_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [PKT_W-1:0]   req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [PKT_W-1:0]   req1_data,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [PKT_W-1:0]   rsp0_data,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [PKT_W-1:0]   rsp1_data,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic [PKT_W-1:0]   pkt_data,
    input  logic               tl_rsp_valid,
    output logic               tl_rsp_ready,
    input  logic [PKT_W-1:0]   tl_rsp_data,
    input  logic               drain,
    output logic               idle,
    output logic               timeout_err,
    output logic [STRAY_W-1:0] stray_count
);

    localparam int unsigned TAG_BIT = SRC_LSB + SRC_W - 1;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES);

    if (MAX_OUTSTANDING == 0 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 2 ||
        SRC_LSB + SRC_W > PKT_W || CLOCK_FREQ == 0) begin : g_bad_params
        $error("stl_txn_arbiter: parameter out of range");
    end

    logic [CNT_W-1:0] cnt0, cnt1;
    logic             full0, full1, zero0, zero1;
    logic             can_load, elig0, elig1, grant0, grant1, last_grant;
    logic             tl_hs, rsp_tag, rsp_stray, deliver0, deliver1;
    logic             to_clr, flush;
    logic [TO_W-1:0]  to_cnt;
    logic             rsp_dst;
    pkt_t             req_tagged, rsp_untagged, rsp_buf;
    rsp_state_e       rsp_state, rsp_state_nxt;

    stl_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr0 (
        .clk(clk), .reset(reset), .inc(grant0), .dec(deliver0), .flush(flush),
        .count(cnt0), .full(full0), .zero(zero0)
    );

    stl_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ctr1 (
        .clk(clk), .reset(reset), .inc(grant1), .dec(deliver1), .flush(flush),
        .count(cnt1), .full(full1), .zero(zero1)
    );

    // Round-robin grant; the buffer may reload in the cycle it is popped
    assign can_load   = !pkt_valid || pkt_ready;
    assign elig0      = !reset && req0_valid && !full0 && !drain && can_load;
    assign elig1      = !reset && req1_valid && !full1 && !drain && can_load;
    assign grant0     = elig0 && (!elig1 || last_grant);
    assign grant1     = elig1 && (!elig0 || !last_grant);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        req_tagged          = grant1 ? req1_data : req0_data;
        req_tagged[TAG_BIT] = grant1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_valid  <= 1'b0;
            pkt_data   <= '0;
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            pkt_valid  <= 1'b1;
            pkt_data   <= req_tagged;
            last_grant <= grant1;
        end else if (pkt_ready) begin
            pkt_valid  <= 1'b0;
        end
    end

    // Response capture and routing by tag bit
    assign tl_rsp_ready = (rsp_state == RSP_EMPTY);
    assign tl_hs        = tl_rsp_valid && tl_rsp_ready;
    assign rsp_tag      = tl_rsp_data[TAG_BIT];
    assign rsp_stray    = rsp_tag ? zero1 : zero0;
    assign rsp0_valid   = (rsp_state == RSP_FULL) && !rsp_dst;
    assign rsp1_valid   = (rsp_state == RSP_FULL) && rsp_dst;
    assign rsp0_data    = rsp_buf;
    assign rsp1_data    = rsp_buf;
    assign deliver0     = rsp0_valid && rsp0_ready;
    assign deliver1     = rsp1_valid && rsp1_ready;

    always_comb begin
        rsp_untagged          = tl_rsp_data;
        rsp_untagged[TAG_BIT] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_state <= RSP_EMPTY;
        end else begin
            rsp_state <= rsp_state_nxt;
        end
    end

    always_comb begin
        rsp_state_nxt = rsp_state;
        case (rsp_state)
            RSP_EMPTY: if (tl_rsp_valid && !rsp_stray) rsp_state_nxt = RSP_FULL;
            RSP_FULL:  if (deliver0 || deliver1) rsp_state_nxt = RSP_EMPTY;
            default:   rsp_state_nxt = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_buf     <= '0;
            rsp_dst     <= 1'b0;
            stray_count <= '0;
        end else if (tl_hs) begin
            if (!rsp_stray) begin
                rsp_buf <= rsp_untagged;
                rsp_dst <= rsp_tag;
            end else if (stray_count != '1) begin
                stray_count <= stray_count + STRAY_W'(1);
            end
        end
    end

    // Timeout watchdog: runs only while something is outstanding and no response arrives
    assign to_clr = tl_hs || (zero0 && zero1);
    assign flush  = !to_clr && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (to_clr || flush) begin
            to_cnt      <= '0;
            timeout_err <= timeout_err || flush;
        end else begin
            to_cnt      <= to_cnt + TO_W'(1);
        end
    end

    assign idle = zero0 && zero1 && !pkt_valid && (rsp_state == RSP_EMPTY);

endmodule
